// File: rtl/neocore_pkg.sv
// Shared NeoCore types and constants used by the fetch memory responder.
// Holds the responder FSM state encoding, the fetch window geometry and a
// small helper that works out how many SRAM beats a fetch needs.
package neocore_pkg;

   typedef enum logic [1:0] {
      FR_IDLE,
      FR_RD,
      FR_WAIT,
      FR_RESP
   } fetch_resp_state_t;

   localparam int FETCH_WIDTH_BYTES = 16;
   localparam int FETCH_WIDTH_BITS  = 8 * FETCH_WIDTH_BYTES;
   // One spare 32-bit word lets an unaligned 16-byte fetch fit in the window
   localparam int FETCH_WINDOW_BITS = FETCH_WIDTH_BITS + 32;

   // An aligned fetch covers exactly four words; any byte offset spills into a fifth
   function automatic logic [2:0] fetch_beats(input logic [1:0] byte_offset);
      return (byte_offset == 2'd0) ? 3'd4 : 3'd5;
   endfunction

endpackage

// File: rtl/fetch_byte_aligner.sv
// Combinational byte aligner: picks the 16-byte big-endian slice out of the
// 160-bit word window, starting at the byte offset of the original request.
module fetch_byte_aligner
   import neocore_pkg::*;
(
   input  logic [FETCH_WINDOW_BITS-1:0] window,
   input  logic [1:0]                   offset,
   output logic [FETCH_WIDTH_BITS-1:0]  slice
);

   // First word sits in the MSBs, so each byte of offset moves the slice down 8 bits
   always_comb begin
      slice = window[FETCH_WINDOW_BITS-1 -: FETCH_WIDTH_BITS];
      case (offset)
         2'd1:    slice = window[FETCH_WINDOW_BITS-9  -: FETCH_WIDTH_BITS];
         2'd2:    slice = window[FETCH_WINDOW_BITS-17 -: FETCH_WIDTH_BITS];
         2'd3:    slice = window[FETCH_WINDOW_BITS-25 -: FETCH_WIDTH_BITS];
         default: slice = window[FETCH_WINDOW_BITS-1  -: FETCH_WIDTH_BITS];
      endcase
   end

endmodule

// File: rtl/fetch_mem_responder.sv
// Memory-side responder for the fetch unit's wide instruction port.
// Serves 16 big-endian bytes from any byte address by issuing four or five
// reads to a 32-bit synchronous SRAM, collecting them in a 160-bit window and
// returning the aligned slice with a one-cycle mem_ack.
// A request is abandoned (no ack) as soon as the fetch unit drops mem_req or
// changes mem_addr, which covers stalls and branch flushes.
// Optional build macro FETCH_BOUNDS_EN: requests whose last byte lies beyond
// the SRAM are answered immediately with mem_err and zero data instead of
// wrapping around the SRAM.
module fetch_mem_responder
   import neocore_pkg::*;
#(
   parameter int MEM_WORDS = 16384,
   parameter int AW        = $clog2(MEM_WORDS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mem_req,
   input  logic [31:0]                 mem_addr,
   output logic [FETCH_WIDTH_BITS-1:0] mem_rdata,
   output logic                        mem_ack,
   output logic                        mem_err,
   output logic                        sram_re,
   output logic [AW-1:0]               sram_addr,
   input  logic [31:0]                 sram_rdata
);

   fetch_resp_state_t            state;
   logic [31:0]                  cap_addr;
   logic [2:0]                   rd_beat;
   logic [2:0]                   wr_beat;
   logic                         data_valid;
   logic [FETCH_WINDOW_BITS-1:0] window;
   logic [FETCH_WINDOW_BITS-1:0] window_next;
   logic [FETCH_WIDTH_BITS-1:0]  aligned;
   logic                         ack_q;
   logic                         abort;
   logic [2:0]                   num_beats;

   assign num_beats = fetch_beats(cap_addr[1:0]);

   // Any change to the held request while busy means the fetch unit no longer wants this data
   assign abort = (state != FR_IDLE) && (!mem_req || (mem_addr != cap_addr));

   // The ack is killed in the same cycle it would appear if the request went away
   assign mem_ack = ack_q && !abort;

   // Drop the returning SRAM word into its slot; first word lands in the MSBs
   always_comb begin
      window_next = window;
      if (data_valid) begin
         window_next[FETCH_WINDOW_BITS-1-32*int'(wr_beat) -: 32] = sram_rdata;
      end
   end

   fetch_byte_aligner u_aligner (
      .window (window_next),
      .offset (cap_addr[1:0]),
      .slice  (aligned)
   );

`ifdef FETCH_BOUNDS_EN
   logic [32:0] last_byte;
   logic        out_of_range;
   logic        err_q;

   assign last_byte    = {1'b0, mem_addr} + 33'd15;
   assign out_of_range = last_byte >= 33'(4 * MEM_WORDS);
   assign mem_err      = err_q && !abort;

   // Remember whether the captured request was out of range until its response cycle ends
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (state == FR_IDLE && mem_req) begin
         err_q <= out_of_range;
      end else if (state == FR_RESP) begin
         err_q <= 1'b0;
      end
   end
`else
   assign mem_err = 1'b0;
`endif

   // Main responder FSM: capture, stream SRAM reads, collect words, respond
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FR_IDLE;
         cap_addr   <= '0;
         rd_beat    <= '0;
         wr_beat    <= '0;
         data_valid <= 1'b0;
         window     <= '0;
         sram_re    <= 1'b0;
         sram_addr  <= '0;
         ack_q      <= 1'b0;
         mem_rdata  <= '0;
      end else begin
         data_valid <= sram_re && !abort;
         if (data_valid) begin
            window  <= window_next;
            wr_beat <= wr_beat + 3'd1;
         end

         case (state)
            FR_IDLE: begin
               ack_q <= 1'b0;
               if (mem_req) begin
                  cap_addr <= mem_addr;
                  rd_beat  <= '0;
                  wr_beat  <= '0;
                  window   <= '0;
`ifdef FETCH_BOUNDS_EN
                  if (out_of_range) begin
                     state     <= FR_RESP;
                     ack_q     <= 1'b1;
                     mem_rdata <= '0;
                  end else begin
`else
                  begin
`endif
                     state     <= FR_RD;
                     sram_re   <= 1'b1;
                     sram_addr <= mem_addr[AW+1:2];
                  end
               end
            end

            FR_RD: begin
               if (abort) begin
                  state   <= FR_IDLE;
                  sram_re <= 1'b0;
               end else if (rd_beat == num_beats - 3'd1) begin
                  state   <= FR_WAIT;
                  sram_re <= 1'b0;
               end else begin
                  rd_beat   <= rd_beat + 3'd1;
                  sram_addr <= sram_addr + AW'(1);
               end
            end

            FR_WAIT: begin
               if (abort) begin
                  state <= FR_IDLE;
               end else begin
                  state     <= FR_RESP;
                  ack_q     <= 1'b1;
                  mem_rdata <= aligned;
               end
            end

            FR_RESP: begin
               state <= FR_IDLE;
               ack_q <= 1'b0;
            end

            default: begin
               state   <= FR_IDLE;
               sram_re <= 1'b0;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_mem_responder.sv
// Self-checking bench for fetch_mem_responder with a small 16-word SRAM so
// wrap-around is exercised often. A driver issues directed and random fetches
// (with stalls, flushes and a mid-read reset) and queues the expected SRAM
// reads and responses; independent monitors pop and compare them.
module tb_fetch_mem_responder;
   import neocore_pkg::*;

   localparam int MEM_WORDS = 16;
   localparam int AW        = $clog2(MEM_WORDS);
   localparam int BYTES     = 4 * MEM_WORDS;

   typedef struct {
      int           cyc;
      logic [127:0] data;
      logic         err;
   } resp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_req;
   logic [31:0]   mem_addr;
   logic [127:0]  mem_rdata;
   logic          mem_ack;
   logic          mem_err;
   logic          sram_re;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_rdata = '0;

   logic [7:0]    mem_bytes [BYTES];
   resp_t         resp_q [$];
   logic [AW-1:0] rd_q [$];
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;

   fetch_mem_responder #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .mem_err    (mem_err),
      .sram_re    (sram_re),
      .sram_addr  (sram_addr),
      .sram_rdata (sram_rdata)
   );

   // Free-running clock and cycle counter shared by driver and monitors
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural SRAM: word k holds bytes 4k..4k+3, big-endian, one cycle read latency
   always @(posedge clk) begin
      if (sram_re) begin
         sram_rdata <= {mem_bytes[4*int'(sram_addr)],   mem_bytes[4*int'(sram_addr)+1],
                        mem_bytes[4*int'(sram_addr)+2], mem_bytes[4*int'(sram_addr)+3]};
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: 16 consecutive bytes from the byte address, wrapping modulo the byte space
   function automatic logic [127:0] model_data(input logic [31:0] a);
      logic [127:0] r;
      for (int j = 0; j < 16; j++) begin
         r[127-8*j -: 8] = mem_bytes[int'((a + 32'(j)) % 32'(BYTES))];
      end
      return r;
   endfunction

   function automatic bit model_err(input logic [31:0] a);
`ifdef FETCH_BOUNDS_EN
      return (longint'(a) + 64'sd15) >= longint'(BYTES);
`else
      return 1'b0;
`endif
   endfunction

   // SRAM read monitor: every read must match the next expected word address
   always @(negedge clk) begin
      if (sram_re) begin
         if (rd_q.size() == 0) begin
            checkOutput("unexpected_sram_re", 128'(sram_addr), 128'hX);
         end else begin
            checkOutput("sram_addr", 128'(sram_addr), 128'(rd_q.pop_front()));
         end
      end
   end

   // Response monitor: acks must arrive exactly when expected with the modelled data
   always @(negedge clk) begin
      resp_t r;
      if (mem_ack) begin
         if (resp_q.size() == 0) begin
            checkOutput("spurious_ack", 128'(mem_ack), 128'(0));
         end else begin
            r = resp_q.pop_front();
            checkOutput("ack_cycle", 128'(cyc), 128'(r.cyc));
            checkOutput("mem_rdata", mem_rdata, r.data);
            checkOutput("mem_err", 128'(mem_err), 128'(r.err));
         end
      end else if (resp_q.size() != 0 && resp_q[0].cyc <= cyc) begin
         r = resp_q.pop_front();
         checkOutput("missing_ack", 128'(mem_ack), 128'(1));
      end
   end

   // One fetch; abort_k>0 disturbs the request in that cycle (drop req or change address)
   task automatic applyStimulus(input logic [31:0] a, input int abort_k, input bit drop,
                                input logic [31:0] alt);
      int    n;
      int    lat;
      int    last;
      bit    err;
      bit    aborted;
      resp_t r;
      err     = model_err(a);
      n       = (a[1:0] == 2'd0) ? 4 : 5;
      lat     = err ? 1 : n + 2;
      aborted = (abort_k >= 1) && (abort_k <= lat);
      last    = aborted ? abort_k : lat;
      mem_req  = 1'b1;
      mem_addr = a;
      if (!err) begin
         for (int i = 0; i < n; i++) begin
            if (!aborted || i < abort_k) rd_q.push_back(AW'(int'(a >> 2) + i));
         end
      end
      if (!aborted) begin
         r.cyc  = cyc + lat;
         r.data = err ? 128'h0 : model_data(a);
         r.err  = err;
         resp_q.push_back(r);
      end
      for (int c = 1; c <= last; c++) begin
         @(posedge clk); #1;
         if (aborted && c == abort_k) begin
            if (drop) mem_req = 1'b0;
            else      mem_addr = alt;
         end
      end
      @(posedge clk); #1;
      mem_req = 1'b0;
   endtask

   task automatic idleCycles(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // Assert reset in cycle 3 of an aligned read and check the reset state right after
   task automatic resetMidRead(input logic [31:0] a);
      mem_req  = 1'b1;
      mem_addr = a;
      for (int i = 0; i < 3; i++) rd_q.push_back(AW'(int'(a >> 2) + i));
      idleCycles(3);
      rst = 1'b1;
      idleCycles(1);
      mem_req = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid_sram_re", 128'(sram_re), 128'(0));
      checkOutput("rst_mid_ack", 128'(mem_ack), 128'(0));
      checkOutput("rst_mid_err", 128'(mem_err), 128'(0));
      checkOutput("rst_mid_rdata", mem_rdata, 128'h0);
      checkOutput("rst_mid_sram_addr", 128'(sram_addr), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Watchdog so the bench always ends even if the driver gets stuck
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios first, then randomized traffic with stalls and flushes
   initial begin
      for (int i = 0; i < BYTES; i++) mem_bytes[i] = 8'(i);
      rst      = 1'b1;
      mem_req  = 1'b0;
      mem_addr = '0;
      idleCycles(3);
      @(negedge clk);
      checkOutput("reset_ack", 128'(mem_ack), 128'(0));
      checkOutput("reset_err", 128'(mem_err), 128'(0));
      checkOutput("reset_rdata", mem_rdata, 128'h0);
      checkOutput("reset_sram_re", 128'(sram_re), 128'(0));
      checkOutput("reset_sram_addr", 128'(sram_addr), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      idleCycles(1);

      applyStimulus(32'h0000_0000, 0, 1'b0, 32'h0);
      applyStimulus(32'h0000_0003, 0, 1'b0, 32'h0);
      idleCycles(1);
      applyStimulus(32'h0000_0010, 3, 1'b1, 32'h0);
      applyStimulus(32'h0000_0020, 0, 1'b0, 32'h0);
      idleCycles(2);
      applyStimulus(32'h0000_0040, 2, 1'b0, 32'h0000_0100);
      applyStimulus(32'h0000_0100, 0, 1'b0, 32'h0);
      applyStimulus(32'h0000_003E, 0, 1'b0, 32'h0);
      applyStimulus(32'h0000_0031, 0, 1'b0, 32'h0);
      applyStimulus(32'h0000_0005, 7, 1'b1, 32'h0);
      idleCycles(2);
      resetMidRead(32'h0000_0008);
      idleCycles(1);
      applyStimulus(32'h0000_0008, 0, 1'b0, 32'h0);

      for (int i = 0; i < BYTES; i++) mem_bytes[i] = 8'($urandom);
      for (int t = 0; t < 80; t++) begin
         logic [31:0] a;
         int          k;
         a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 80));
         k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
         applyStimulus(a, k, 1'($urandom_range(0, 1)), a ^ (32'h1 << $urandom_range(0, 31)));
         idleCycles(int'($urandom_range(0, 2)));
      end

      idleCycles(10);
      checkOutput("pending_responses", 128'(resp_q.size()), 128'(0));
      checkOutput("pending_sram_reads", 128'(rd_q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
